// File: rtl/regfile_bus_if_pkg.sv
// rtl/regfile_bus_if_pkg.sv - shared constants and FSM encodings for the register file bus front end
//
// Purpose: active-low enable levels, access-type codes, default geometry and
// the 2-bit FSM state encoding shared by regfile_bus_if and regfile_clr_seq.
// Ports: none (package).

package regfile_bus_if_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DATA_D = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - soft-clear sweep counter and one-shot arm flag
//
// Purpose: walks cnt 0..DATA_D-1 while the top-level FSM is sweeping and
// keeps an arm flag so a clear_ held low produces only one sweep.
// Ports:
//   clk, reset_   clock, asynchronous active-low reset
//   clear_i       soft-clear request level (active-low)
//   start_i       FSM is entering the sweep this cycle
//   step_i        FSM is in the sweep state
//   armed_o       a new sweep may be started
//   cnt_o         entry currently being cleared
//   last_o        cnt_o is the final entry

module regfile_clr_seq
  import regfile_bus_if_pkg::*;
#(
  parameter int DATA_D = DEF_DATA_D,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              step_i,
  output logic              armed_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DATA_D - 1);

  logic              armed_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      armed_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      // Re-arm only after the request has been seen released.
      if (start_i) begin
        armed_q <= 1'b0;
      end else if (clear_i == DISABLE_) begin
        armed_q <= 1'b1;
      end

      if (start_i) begin
        cnt_q <= '0;
      end else if (step_i && !last_o) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
    end
  end

  assign armed_o = armed_q;
  assign cnt_o   = cnt_q;
  assign last_o  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/regfile_bus_if.sv
// rtl/regfile_bus_if.sv - bus slave front end for the single-port register file
//
// Purpose: turns active-low cs_/as_/rw bus transactions into one-cycle
// register file accesses, returns read data with a one-cycle rdy_ pulse,
// and optionally zeroes every entry on a soft-clear request.
// Build option: REGFILE_IF_CLEAR_EN compiles in the clear sweep; without it
// clear_ is ignored and busy is held at 0.
// Ports:
//   clk, reset_            clock, asynchronous active-low reset
//   cs_, as_, rw           chip select, address strobe (active-low), READ=1/WRITE=0
//   bus_addr, bus_wr_data  request address and write data
//   bus_rd_data, rdy_      registered read data, completion pulse (active-low)
//   clear_, busy           soft-clear request (active-low), sweep in progress
//   rf_addr, rf_d_in, rf_we_, rf_d_out   register file access port

module regfile_bus_if
  import regfile_bus_if_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DATA_D = DEF_DATA_D,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic [DATA_W-1:0] bus_rd_data,
  output logic              rdy_,
  input  logic              clear_,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  state_e state_q;
  logic   rw_q;
  logic   oor_q;
  logic   addr_ok;
  logic   bus_req;
  logic   clr_start;

  assign addr_ok = (int'(bus_addr) < DATA_D);
  assign bus_req = (cs_ == ENABLE_) && (as_ == ENABLE_);

`ifdef REGFILE_IF_CLEAR_EN
  logic              clr_armed;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_cnt;

  assign clr_start = (state_q == ST_IDLE) && (clear_ == ENABLE_) && clr_armed;

  regfile_clr_seq #(
    .DATA_D (DATA_D),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset_  (reset_),
    .clear_i (clear_),
    .start_i (clr_start),
    .step_i  (state_q == ST_CLEAR),
    .armed_o (clr_armed),
    .cnt_o   (clr_cnt),
    .last_o  (clr_last)
  );
`else
  logic unused_clear_in;

  assign clr_start       = 1'b0;
  assign unused_clear_in = clear_;
  assign busy            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      rw_q        <= READ;
      oor_q       <= 1'b0;
      bus_rd_data <= '0;
      rdy_        <= DISABLE_;
      rf_we_      <= DISABLE_;
      rf_addr     <= '0;
      rf_d_in     <= '0;
`ifdef REGFILE_IF_CLEAR_EN
      busy        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdy_   <= DISABLE_;
          rf_we_ <= DISABLE_;
          if (clr_start) begin
            // Clear wins over a simultaneous bus request; the request
            // stays pending on the bus and is taken after the sweep.
            state_q <= ST_CLEAR;
            rf_addr <= '0;
            rf_d_in <= '0;
            rf_we_  <= ENABLE_;
`ifdef REGFILE_IF_CLEAR_EN
            busy    <= 1'b1;
`endif
          end else if (bus_req) begin
            state_q <= ST_ACCESS;
            rw_q    <= rw;
            oor_q   <= !addr_ok;
            rf_addr <= bus_addr;
            rf_d_in <= bus_wr_data;
            // Out-of-range writes still complete but never strobe we_.
            rf_we_  <= ((rw == WRITE) && addr_ok) ? ENABLE_ : DISABLE_;
          end
        end

        ST_ACCESS: begin
          rf_we_  <= DISABLE_;
          rdy_    <= ENABLE_;
          state_q <= ST_DONE;
          if (rw_q == READ) begin
            bus_rd_data <= oor_q ? '0 : rf_d_out;
          end
        end

        ST_DONE: begin
          rdy_    <= DISABLE_;
          state_q <= ST_IDLE;
        end

`ifdef REGFILE_IF_CLEAR_EN
        ST_CLEAR: begin
          if (clr_last) begin
            state_q <= ST_IDLE;
            rf_we_  <= DISABLE_;
            busy    <= 1'b0;
          end else begin
            rf_addr <= clr_cnt + ADDR_W'(1);
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          rdy_    <= DISABLE_;
          rf_we_  <= DISABLE_;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_if.sv
// tb/tb_regfile_bus_if.sv - scoreboard bench for regfile_bus_if with a register file model

module tb_regfile_bus_if;

  localparam int DW = 32;
  localparam int DD = 32;
  localparam int AW = 5;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rdy_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
    logic          busy;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          reset_;
  logic          cs_, as_, rw, clear_;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          rdy_, busy;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in, rf_d_out;
  logic          rf_we_;

  logic [DW-1:0] mem [DD];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rd = '0;

  rdy_exp_t rdy_q[$];
  wr_exp_t  wr_q[$];
  rdy_exp_t mon_r;
  wr_exp_t  mon_w;

  regfile_bus_if #(.DATA_W(DW), .DATA_D(DD), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .cs_         (cs_),
    .as_         (as_),
    .rw          (rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .rdy_        (rdy_),
    .clear_      (clear_),
    .busy        (busy),
    .rf_addr     (rf_addr),
    .rf_d_in     (rf_d_in),
    .rf_we_      (rf_we_),
    .rf_d_out    (rf_d_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < DD; i++) mem[i] = 32'h1000_0000 + i;
  end
  always @(posedge clk) if (rf_we_ == 1'b0) mem[rf_addr] <= rf_d_in;
  assign rf_d_out = mem[rf_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_) begin
      if (rdy_ == 1'b0) begin
        if (rdy_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdy_unexpected: rdy_=0 at cycle %0d, required no pulse", cyc);
        end else begin
          mon_r = rdy_q.pop_front();
          chk("rdy_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("bus_rd_data", 64'(bus_rd_data), 64'(mon_r.data));
        end
      end
      if (rf_we_ == 1'b0) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: rf_we_=0 addr=%0d at cycle %0d, required no write", rf_addr, cyc);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
          chk("wr_addr", 64'(rf_addr), 64'(mon_w.addr));
          chk("wr_data", 64'(rf_d_in), 64'(mon_w.data));
          chk("wr_busy", 64'(busy), 64'(mon_w.busy));
        end
      end
    end
  end

  // Caller is at a negedge with the DUT idle; extra delays acceptance by that many cycles.
  task automatic start_req(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_rd, input int extra);
    rdy_exp_t r;
    wr_exp_t  w;
    cs_ = 1'b0; as_ = 1'b0; rw = rd; bus_addr = a; bus_wr_data = d;
    if (rd) last_rd = exp_rd;
    r.data = last_rd;
    r.cyc  = cyc + 2 + extra;
    rdy_q.push_back(r);
    if (!rd) begin
      w.addr = a; w.data = d; w.cyc = cyc + 1 + extra; w.busy = 1'b0;
      wr_q.push_back(w);
    end
  endtask

  task automatic wait_rdy(input int max_cyc);
    bit seen = 0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (rdy_ === 1'b0) seen = 1;
    end
    if (!seen) chk("rdy_timeout", 64'(0), 64'(1));
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic bus_xfer(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd);
    @(negedge clk);
    start_req(rd, a, d, exp_rd, 0);
    wait_rdy(10);
  endtask

  task automatic push_sweep(input int n);
    wr_exp_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = AW'(i); w.data = '0; w.cyc = cyc + 1 + i; w.busy = 1'b1;
      wr_q.push_back(w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_ = 1'b0; clear_ = 1'b0; cs_ = 1'b0; as_ = 1'b0; rw = 1'b0;
    bus_addr = 5'd7; bus_wr_data = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("reset_rf_we_", 64'(rf_we_), 64'(1));
    end
    chk("reset_bus_rd_data", 64'(bus_rd_data), 64'(0));
    chk("reset_rdy_", 64'(rdy_), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_rf_addr", 64'(rf_addr), 64'(0));
    chk("reset_rf_d_in", 64'(rf_d_in), 64'(0));
    cs_ = 1'b1; as_ = 1'b1; clear_ = 1'b1; rw = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read, plus a read of an untouched entry and a second write.
    bus_xfer(1'b0, 5'd3, 32'hDEAD_BEEF, 'x);
    bus_xfer(1'b1, 5'd3, 32'h0, 32'hDEAD_BEEF);
    bus_xfer(1'b1, 5'd7, 32'h0, 32'h1000_0007);
    bus_xfer(1'b0, 5'd31, 32'h0BAD_F00D, 'x);
    bus_xfer(1'b1, 5'd31, 32'h0, 32'h0BAD_F00D);

    // Back-to-back: as_ held low for 9 cycles gives pulses 3 cycles apart.
    @(negedge clk);
    c = cyc;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; bus_addr = 5'd3;
    last_rd = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) rdy_q.push_back('{data: 32'hDEAD_BEEF, cyc: c + 2 + 3 * i});
    repeat (9) @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    repeat (3) @(negedge clk);

`ifdef REGFILE_IF_CLEAR_EN
    bus_xfer(1'b0, 5'd0, 32'h1111_1111, 'x);
    bus_xfer(1'b0, 5'd15, 32'h2222_2222, 'x);
    bus_xfer(1'b0, 5'd31, 32'h3333_3333, 'x);

    // Single clear pulse: 32 writes, busy high until C0+32.
    @(negedge clk);
    c = cyc;
    clear_ = 1'b0;
    push_sweep(DD);
    @(negedge clk);
    clear_ = 1'b1;
    while (cyc < c + 32) @(negedge clk);
    chk("busy_last_sweep_cycle", 64'(busy), 64'(1));
    @(negedge clk);
    chk("busy_after_sweep", 64'(busy), 64'(0));
    bus_xfer(1'b1, 5'd0, 32'h0, 32'h0);
    bus_xfer(1'b1, 5'd15, 32'h0, 32'h0);
    bus_xfer(1'b1, 5'd31, 32'h0, 32'h0);

    // clear_ held low for 100 cycles: only one sweep.
    @(negedge clk);
    clear_ = 1'b0;
    push_sweep(DD);
    repeat (100) @(negedge clk);
    chk("busy_hold_low", 64'(busy), 64'(0));
    clear_ = 1'b1;
    repeat (2) @(negedge clk);

    // Clear and write together: sweep first, write accepted at C0+33.
    @(negedge clk);
    clear_ = 1'b0;
    push_sweep(DD);
    start_req(1'b0, 5'd5, 32'h1234_5678, 'x, 33);
    @(negedge clk);
    clear_ = 1'b1;
    wait_rdy(40);
    bus_xfer(1'b1, 5'd5, 32'h0, 32'h1234_5678);
    bus_xfer(1'b0, 5'd20, 32'hCAFE_F00D, 'x);

    // Reset at sweep cycle 10: entries 0..9 cleared, nothing after.
    @(negedge clk);
    c = cyc;
    clear_ = 1'b0;
    push_sweep(10);
    while (cyc < c + 10) @(negedge clk);
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    clear_ = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("reset_sweep_busy", 64'(busy), 64'(0));
    chk("reset_sweep_rf_we_", 64'(rf_we_), 64'(1));
    reset_ = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'(0));
    bus_xfer(1'b1, 5'd5, 32'h0, 32'h0);
    bus_xfer(1'b1, 5'd20, 32'h0, 32'hCAFE_F00D);
`else
    // Clear disabled: clear_ ignored, busy stays 0, no writes issued.
    @(negedge clk);
    clear_ = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("busy_disabled", 64'(busy), 64'(0));
    end
    // Clear and write together: write runs with normal timing.
    start_req(1'b0, 5'd5, 32'h1234_5678, 'x, 0);
    wait_rdy(10);
    clear_ = 1'b1;
    bus_xfer(1'b1, 5'd5, 32'h0, 32'h1234_5678);
    bus_xfer(1'b1, 5'd3, 32'h0, 32'hDEAD_BEEF);
`endif

    // Reset during an ACCESS cycle: no rdy_ pulse, no write committed.
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; bus_addr = 5'd9; bus_wr_data = 32'h5555_5555;
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    cs_ = 1'b1; as_ = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("reset_access_rdy_", 64'(rdy_), 64'(1));
    chk("reset_access_rf_we_", 64'(rf_we_), 64'(1));
    reset_ = 1'b1;
    repeat (3) @(negedge clk);
`ifdef REGFILE_IF_CLEAR_EN
    bus_xfer(1'b1, 5'd9, 32'h0, 32'h0);
`else
    bus_xfer(1'b1, 5'd9, 32'h0, 32'h1000_0009);
`endif

    repeat (5) @(negedge clk);
    chk("rdy_queue_empty", 64'(rdy_q.size()), 64'(0));
    chk("wr_queue_empty", 64'(wr_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
